// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and writeback codes for the multdiv issue controller and the
// regfile/bypass logic that decodes $rstatus.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int DEF_TIMEOUT     = 64;
  localparam int DEF_RSTATUS_REG = 30;
  localparam int DEF_MULT_EXC    = 4;
  localparam int DEF_DIV_EXC     = 5;
  localparam int DEF_TMO_EXC     = 6;

  // Exactly one of MULT/DIV must be set for an op to be issuable.
  function automatic logic op_legal(input logic is_mult, input logic is_div);
    return is_mult ^ is_div;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Execute-stage / multdiv / writeback bundle seen by the issue controller.
interface multdiv_issue_ctrl_if;
  logic        issue_valid;
  logic        is_mult;
  logic        is_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // master: pipeline + multdiv side driving the controller
  modport master (
    output issue_valid, is_mult, is_div, issue_a, issue_b, issue_rd, flush,
    output md_result, md_exception, md_ready,
    input  md_a, md_b, md_ctrl_mult, md_ctrl_div, stall, wb_valid, wb_rd, wb_data
  );

  // slave: the issue controller itself
  modport slave (
    input  issue_valid, is_mult, is_div, issue_a, issue_b, issue_rd, flush,
    input  md_result, md_exception, md_ready,
    output md_a, md_b, md_ctrl_mult, md_ctrl_div, stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_issue_ctrl_md_cycle_counter.sv
// Busy-cycle counter with synchronous clear; term_o flags the last allowed busy cycle.
module md_cycle_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic term_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall controller in front of multdiv: registers operands, pulses the start
// strobe, holds the pipeline until the result returns, and emits one writeback beat.
module multdiv_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int RSTATUS_REG = DEF_RSTATUS_REG,
  parameter int MULT_EXC    = DEF_MULT_EXC,
  parameter int DIV_EXC     = DEF_DIV_EXC,
  parameter int TMO_EXC     = DEF_TMO_EXC
) (
  input  logic                 clock,
  input  logic                 reset_n,
  multdiv_issue_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        accept;
  logic        cnt_clr, cnt_en, cnt_term;

  md_cycle_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clear_i   (cnt_clr),
    .en_i      (cnt_en),
    .term_o    (cnt_term)
  );

  // DONE accepts too, so a waiting op issues in the same cycle as the writeback.
  assign accept = bus.issue_valid & op_legal(bus.is_mult, bus.is_div) &
                  ((state_q == IDLE) | (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    case (state_q)
      IDLE: if (accept) state_d = START;
      START: begin
        cnt_clr = 1'b1;
        state_d = bus.flush ? IDLE : BUSY;
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.md_ready) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          if (bus.md_exception) begin
            wb_rd_d   = 5'(RSTATUS_REG);
            wb_data_d = (op_q == OP_MULT) ? 32'(MULT_EXC) : 32'(DIV_EXC);
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = bus.md_result;
          end
        end else if (cnt_term) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = 5'(RSTATUS_REG);
          wb_data_d  = 32'(TMO_EXC);
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Operands stay put until the next accepted op, so multdiv may sample late.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
      op_q <= OP_MULT;
    end else if (accept) begin
      a_q  <= bus.issue_a;
      b_q  <= bus.issue_b;
      rd_q <= bus.issue_rd;
      op_q <= bus.is_div ? OP_DIV : OP_MULT;
    end
  end

  assign bus.md_a         = a_q;
  assign bus.md_b         = b_q;
  assign bus.md_ctrl_mult = (state_q == START) & (op_q == OP_MULT);
  assign bus.md_ctrl_div  = (state_q == START) & (op_q == OP_DIV);
  assign bus.stall        = accept | (state_q == START) | (state_q == BUSY);
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expected writebacks.
module tb_multdiv_issue_ctrl;

  localparam int TMO = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multdiv_issue_ctrl_if bus();

  multdiv_issue_ctrl #(.TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one op in flight; age counts cycles since it was accepted
  // (age 1 = start-pulse cycle, age >= 2 = waiting on multdiv).
  bit          m_active, m_wb, m_div;
  int          m_age;
  logic [31:0] m_a, m_b, m_wb_data;
  logic [4:0]  m_rd, m_wb_rd;

  always @(posedge clock or negedge reset_n) begin
    bit          n_active, n_wb, acc;
    int          n_age;
    logic [4:0]  n_wb_rd;
    logic [31:0] n_wb_data;
    if (!reset_n) begin
      m_active <= 0; m_wb <= 0; m_div <= 0; m_age <= 0;
      m_a <= '0; m_b <= '0; m_rd <= '0; m_wb_rd <= '0; m_wb_data <= '0;
    end else begin
      acc       = bus.issue_valid & (bus.is_mult ^ bus.is_div) & !m_active;
      n_active  = m_active;
      n_age     = m_age;
      n_wb      = 0;
      n_wb_rd   = '0;
      n_wb_data = '0;
      if (m_active) begin
        if (bus.flush) n_active = 0;
        else if (m_age == 1) n_age = m_age + 1;
        else if (bus.md_ready) begin
          n_active = 0;
          n_wb     = 1;
          if (bus.md_exception) begin
            n_wb_rd   = 5'd30;
            n_wb_data = m_div ? 32'd5 : 32'd4;
          end else begin
            n_wb_rd   = m_rd;
            n_wb_data = bus.md_result;
          end
        end else if (m_age - 1 == TMO) begin
          n_active  = 0;
          n_wb      = 1;
          n_wb_rd   = 5'd30;
          n_wb_data = 32'd6;
        end else n_age = m_age + 1;
      end
      if (acc) begin
        n_active = 1;
        n_age    = 1;
        m_a   <= bus.issue_a;
        m_b   <= bus.issue_b;
        m_rd  <= bus.issue_rd;
        m_div <= bus.is_div;
      end
      m_active  <= n_active;
      m_age     <= n_age;
      m_wb      <= n_wb;
      m_wb_rd   <= n_wb_rd;
      m_wb_data <= n_wb_data;
    end
  end

  always @(negedge clock) begin
    bit acc_now;
    acc_now = bus.issue_valid & (bus.is_mult ^ bus.is_div) & !m_active;
    chk("stall",      32'(bus.stall),        32'(acc_now | m_active));
    chk("pulse_mult", 32'(bus.md_ctrl_mult), 32'(m_active && m_age == 1 && !m_div));
    chk("pulse_div",  32'(bus.md_ctrl_div),  32'(m_active && m_age == 1 && m_div));
    chk("wb_valid",   32'(bus.wb_valid),     32'(m_wb));
    chk("wb_rd",      32'(bus.wb_rd),        32'(m_wb_rd));
    chk("wb_data",    bus.wb_data,           m_wb_data);
    chk("md_a",       bus.md_a,              m_a);
    chk("md_b",       bus.md_b,              m_b);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.issue_valid = 1; bus.is_mult = !div; bus.is_div = div;
    bus.issue_a = a; bus.issue_b = b; bus.issue_rd = rd;
  endtask

  task automatic drop();
    bus.issue_valid = 0; bus.is_mult = 0; bus.is_div = 0;
  endtask

  // Stub multdiv: ready after lat cycles in the pulse-to-ready window.
  task automatic respond(input int lat, input bit exc, input logic [31:0] res);
    repeat (lat) tick();
    bus.md_ready = 1; bus.md_exception = exc; bus.md_result = res;
    tick();
    bus.md_ready = 0; bus.md_exception = 0; bus.md_result = '0;
  endtask

  task automatic chk_wb(input string nm, input logic [4:0] rd, input logic [31:0] data);
    chk({nm, "_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({nm, "_rd"},    32'(bus.wb_rd),    32'(rd));
    chk({nm, "_data"},  bus.wb_data,       data);
  endtask

  initial begin
    int n;
    bus.flush = 0; bus.md_ready = 0; bus.md_exception = 0; bus.md_result = '0;
    bus.issue_a = '0; bus.issue_b = '0; bus.issue_rd = '0;
    drop();
    repeat (3) tick();
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_md_a", bus.md_a, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    reset_n = 1;
    tick();

    // MULT 7*6 -> r3 = 42
    issue(0, 32'd7, 32'd6, 5'd3); tick(); drop();
    chk("t1_pulse", 32'(bus.md_ctrl_mult), 32'd1);
    chk("t1_md_a", bus.md_a, 32'd7);
    chk("t1_stall", 32'(bus.stall), 32'd1);
    respond(17, 0, 32'd42);
    chk_wb("t1_wb", 5'd3, 32'd42);
    chk("t1_stall_done", 32'(bus.stall), 32'd0);
    tick();
    chk("t1_wb_once", 32'(bus.wb_valid), 32'd0);

    // DIV 100/0 -> divide-by-zero code; flush during DONE must not cancel it
    issue(1, 32'd100, 32'd0, 5'd4); tick(); drop();
    chk("t2_pulse", 32'(bus.md_ctrl_div), 32'd1);
    respond(33, 1, 32'd0);
    bus.flush = 1;
    chk_wb("t2_wb", 5'd30, 32'd5);
    tick(); bus.flush = 0;
    chk("t2_wb_once", 32'(bus.wb_valid), 32'd0);

    // MULT overflow -> mult exception code
    issue(0, 32'h7FFF_FFFF, 32'd2, 5'd5); tick(); drop();
    respond(5, 1, 32'd0);
    chk_wb("t3_wb", 5'd30, 32'd4);
    tick();

    // multdiv never answers -> timeout writeback
    issue(0, 32'd3, 32'd3, 5'd6); tick(); drop();
    n = 0;
    while (!bus.wb_valid && n < 200) begin tick(); n++; end
    chk("t4_tmo_cycles", 32'(n), 32'(TMO + 1));
    chk_wb("t4_wb", 5'd30, 32'd6);
    tick();

    // flush in BUSY, coinciding with md_ready: result discarded
    issue(0, 32'd5, 32'd5, 5'd7); tick(); drop();
    repeat (3) tick();
    bus.flush = 1; bus.md_ready = 1; bus.md_result = 32'd25;
    tick();
    bus.flush = 0; bus.md_ready = 0; bus.md_result = '0;
    chk("t5_no_wb", 32'(bus.wb_valid), 32'd0);
    chk("t5_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("t5_no_wb2", 32'(bus.wb_valid), 32'd0);
    issue(1, 32'd9, 32'd3, 5'd8); tick(); drop();
    chk("t5_pulse", 32'(bus.md_ctrl_div), 32'd1);
    chk("t5_md_a", bus.md_a, 32'd9);
    respond(33, 0, 32'd3);
    chk_wb("t5_wb", 5'd8, 32'd3);
    tick();

    // illegal op (both bits) is ignored
    bus.issue_valid = 1; bus.is_mult = 1; bus.is_div = 1;
    #1;
    chk("t6_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("t6_no_pulse", 32'(bus.md_ctrl_mult | bus.md_ctrl_div), 32'd0);
    drop(); tick();

    // back-to-back: second op accepted in the writeback cycle
    issue(0, 32'd2, 32'd3, 5'd1); tick(); drop();
    respond(2, 0, 32'd6);
    issue(1, 32'd8, 32'd2, 5'd2);
    #1;
    chk_wb("t7_wb1", 5'd1, 32'd6);
    chk("t7_stall_acc", 32'(bus.stall), 32'd1);
    tick(); drop();
    chk("t7_pulse2", 32'(bus.md_ctrl_div), 32'd1);
    chk("t7_md_a2", bus.md_a, 32'd8);
    respond(2, 0, 32'd4);
    chk_wb("t7_wb2", 5'd2, 32'd4);
    tick();

    // async reset mid-BUSY clears outputs immediately, no writeback afterwards
    issue(0, 32'd11, 32'd12, 5'd9); tick(); drop();
    repeat (3) tick();
    #2 reset_n = 0;
    #1;
    chk("t8_stall", 32'(bus.stall), 32'd0);
    chk("t8_md_a", bus.md_a, 32'd0);
    chk("t8_md_b", bus.md_b, 32'd0);
    chk("t8_wb", 32'(bus.wb_valid), 32'd0);
    tick(); tick();
    reset_n = 1;
    repeat (3) tick();
    chk("t8_idle_stall", 32'(bus.stall), 32'd0);
    chk("t8_idle_wb", 32'(bus.wb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
